vga_sync_to_count: RTL and testbench

- Receive side of the VGA sync interface: takes HSync/VSync pulses as produced by the team's sync generator and recovers aligned column/row counters.
- Adds frame-start detection, timing checking and a lock state machine.
- Sits between the sync generator and downstream pixel-drawing logic (Pong paddles/ball), so consumers read counters aligned with the registered sync outputs.

---
 rtl/vga_timing_pkg.sv | 15 +
 rtl/vga_lock_fsm.sv | 82 ++++++++
 rtl/vga_sync_to_count.sv | 79 +++++++
 tb/tb_vga_sync_to_count.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing constants and lock FSM state encoding for the VGA sync receiver.
package vga_timing_pkg;
  localparam int unsigned CNT_W       = 10;
  localparam int unsigned LOCK_CNT_W  = 4;
  localparam int unsigned TOTAL_COLS  = 800;
  localparam int unsigned TOTAL_ROWS  = 525;
  localparam int unsigned ACTIVE_COLS = 640;
  localparam int unsigned ACTIVE_ROWS = 480;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;
endpackage

// File: rtl/vga_lock_fsm.sv
// Frame lock state machine: counts good frame boundaries and flags timing mismatches.
module vga_lock_fsm
  import vga_timing_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Rise,
  input  logic i_Term,
  output logic o_Frame_Err,
  output logic o_Locked
);

  lock_state_t           r_state;
  lock_state_t           w_state_nxt;
  logic [LOCK_CNT_W-1:0] r_good_cnt;
  logic [LOCK_CNT_W-1:0] w_good_cnt_nxt;
  logic [LOCK_CNT_W-1:0] w_good_inc;
  logic                  r_frame_err;
  logic                  r_locked;
  logic                  w_good;
  logic                  w_bad;
  logic                  w_err;

  assign w_good     = i_Rise & i_Term;
  assign w_bad      = i_Rise ^ i_Term;
  assign w_good_inc = r_good_cnt + LOCK_CNT_W'(1);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= SEARCH;
      r_good_cnt  <= '0;
      r_frame_err <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_good_cnt  <= w_good_cnt_nxt;
      r_frame_err <= w_err;
      r_locked    <= (w_state_nxt == LOCKED);
    end
  end

  // Errors are only reported once a first VSync edge has been seen.
  always_comb begin
    w_state_nxt    = r_state;
    w_good_cnt_nxt = r_good_cnt;
    w_err          = 1'b0;
    case (r_state)
      SEARCH: begin
        if (i_Rise) begin
          w_state_nxt    = VERIFY;
          w_good_cnt_nxt = '0;
        end
      end
      VERIFY: begin
        if (w_good) begin
          w_good_cnt_nxt = w_good_inc;
          if (w_good_inc == LOCK_CNT_W'(LOCK_FRAMES)) w_state_nxt = LOCKED;
        end else if (w_bad) begin
          w_good_cnt_nxt = '0;
          w_err          = 1'b1;
        end
      end
      LOCKED: begin
        if (w_bad) begin
          w_state_nxt    = VERIFY;
          w_good_cnt_nxt = '0;
          w_err          = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = SEARCH;
        w_good_cnt_nxt = '0;
      end
    endcase
  end

  assign o_Frame_Err = r_frame_err;
  assign o_Locked    = r_locked;

endmodule

// File: rtl/vga_sync_to_count.sv
// VGA sync receiver: registers HSync/VSync and recovers column/row counters aligned with them.
module vga_sync_to_count #(
  parameter int unsigned TOTAL_COLS  = vga_timing_pkg::TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS  = vga_timing_pkg::TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS = vga_timing_pkg::ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS = vga_timing_pkg::ACTIVE_ROWS,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Frame_Start,
  output logic       o_Frame_Err,
  output logic       o_Locked,
  output logic       o_Active
);

  localparam int unsigned CNT_W = vga_timing_pkg::CNT_W;

  logic             r_hsync;
  logic             r_vsync;
  logic [CNT_W-1:0] r_col;
  logic [CNT_W-1:0] r_row;
  logic             r_frame_start;
  logic             w_rise;
  logic             w_term;

  assign w_rise = i_VSync & ~r_vsync;
  assign w_term = (r_col == CNT_W'(TOTAL_COLS - 1)) && (r_row == CNT_W'(TOTAL_ROWS - 1));

  // Sync registers reset high so a sync already high at release is not seen as an edge.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_col         <= '0;
      r_row         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= i_HSync;
      r_vsync       <= i_VSync;
      r_frame_start <= w_rise;
      if (w_rise) begin
        r_col <= '0;
        r_row <= '0;
      end else if (r_col >= CNT_W'(TOTAL_COLS - 1)) begin
        r_col <= '0;
        if (r_row >= CNT_W'(TOTAL_ROWS - 1)) r_row <= '0;
        else                                 r_row <= r_row + CNT_W'(1);
      end else begin
        r_col <= r_col + CNT_W'(1);
      end
    end
  end

  vga_lock_fsm #(
    .LOCK_FRAMES(LOCK_FRAMES)
  ) u_lock_fsm (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Rise     (w_rise),
    .i_Term     (w_term),
    .o_Frame_Err(o_Frame_Err),
    .o_Locked   (o_Locked)
  );

  assign o_HSync       = r_hsync;
  assign o_VSync       = r_vsync;
  assign o_Col_Count   = r_col;
  assign o_Row_Count   = r_row;
  assign o_Frame_Start = r_frame_start;
  assign o_Active      = (r_col < CNT_W'(ACTIVE_COLS)) && (r_row < CNT_W'(ACTIVE_ROWS));

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Directed bench for vga_sync_to_count using a reduced 40x12 frame so many frames fit in a short run.
module tb_vga_sync_to_count;

  localparam int TC = 40;
  localparam int TR = 12;
  localparam int AC = 32;
  localparam int AR = 10;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_HSync = 1'b1;
  logic       i_VSync = 1'b1;
  logic       o_HSync, o_VSync, o_Frame_Start, o_Frame_Err, o_Locked, o_Active;
  logic [9:0] o_Col_Count, o_Row_Count;

  int n_vec = 0;
  int n_err = 0;
  int gen_col = 5;
  int gen_row = 3;
  int err_seen = 0;
  bit late = 1'b0;
  bit novs = 1'b0;

  vga_sync_to_count #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR),
    .LOCK_FRAMES(2)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_HSync      (i_HSync),
    .i_VSync      (i_VSync),
    .o_HSync      (o_HSync),
    .o_VSync      (o_VSync),
    .o_Col_Count  (o_Col_Count),
    .o_Row_Count  (o_Row_Count),
    .o_Frame_Start(o_Frame_Start),
    .o_Frame_Err  (o_Frame_Err),
    .o_Locked     (o_Locked),
    .o_Active     (o_Active)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Sync generator model: HSync high over active columns, VSync high over active rows.
  task automatic tick();
    i_HSync = (gen_col < AC);
    if (novs)                                  i_VSync = 1'b1;
    else if (late && gen_row == 0 && gen_col < 5) i_VSync = 1'b0;
    else                                       i_VSync = (gen_row < AR);
    @(posedge i_Clk);
    #1;
    if (o_Frame_Err === 1'b1) err_seen++;
    if (gen_col == TC - 1) begin
      gen_col = 0;
      gen_row = (gen_row == TR - 1) ? 0 : gen_row + 1;
    end else begin
      gen_col = gen_col + 1;
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_cnt(input string tag, input int col, input int row);
    chk({tag, "_col"}, 32'(o_Col_Count), 32'(col));
    chk({tag, "_row"}, 32'(o_Row_Count), 32'(row));
  endtask

  task automatic wait_fs(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      tick();
      if (o_Frame_Start === 1'b1) found = 1'b1;
    end
    chk({tag, "_found"}, 32'(found), 32'd1);
  endtask

  initial begin
    // Reset with both syncs high.
    tick_n(3);
    chk("rst_hs", 32'(o_HSync), 32'd1);
    chk("rst_vs", 32'(o_VSync), 32'd1);
    chk_cnt("rst", 0, 0);
    chk("rst_lock", 32'(o_Locked), 32'd0);
    chk("rst_fs", 32'(o_Frame_Start), 32'd0);
    chk("rst_err", 32'(o_Frame_Err), 32'd0);
    chk("rst_act", 32'(o_Active), 32'd1);

    i_Rst = 1'b0;
    tick();
    chk("rel_fs", 32'(o_Frame_Start), 32'd0);
    chk("rel_vs", 32'(o_VSync), 32'd1);
    chk_cnt("rel", 1, 0);

    // First VSync rise from mid-frame.
    err_seen = 0;
    wait_fs("fs1");
    chk_cnt("fs1", 0, 0);
    chk("fs1_err_seen", 32'(err_seen), 32'd0);
    chk("fs1_lock", 32'(o_Locked), 32'd0);

    // First good frame.
    tick_n(TC * TR - 1);
    chk_cnt("f1_end", TC - 1, TR - 1);
    tick();
    chk("f1_fs", 32'(o_Frame_Start), 32'd1);
    chk_cnt("f1_fs", 0, 0);
    chk("f1_lock", 32'(o_Locked), 32'd0);

    // Second good frame, with active-area boundaries.
    tick_n(9 * TC + 31);
    chk_cnt("act_in", 31, 9);
    chk("act_in", 32'(o_Active), 32'd1);
    tick();
    chk("act_col", 32'(o_Active), 32'd0);
    tick_n(8);
    chk_cnt("act_row", 0, 10);
    chk("act_row", 32'(o_Active), 32'd0);
    chk("vs_low", 32'(o_VSync), 32'd0);
    tick_n(79);
    chk("f2_prelock", 32'(o_Locked), 32'd0);
    tick();
    chk("f2_fs", 32'(o_Frame_Start), 32'd1);
    chk("f2_lock", 32'(o_Locked), 32'd1);
    chk("f2_err_seen", 32'(err_seen), 32'd0);

    // VSync rise delayed by 5 clocks.
    tick_n(TC * TR - 1);
    late = 1'b1;
    tick();
    chk("late_wrap_err", 32'(o_Frame_Err), 32'd1);
    chk("late_wrap_fs", 32'(o_Frame_Start), 32'd0);
    chk_cnt("late_wrap", 0, 0);
    chk("late_wrap_lock", 32'(o_Locked), 32'd0);
    tick_n(4);
    chk_cnt("late_run", 4, 0);
    chk("late_run_err", 32'(o_Frame_Err), 32'd0);
    tick();
    late = 1'b0;
    chk("late_rise_err", 32'(o_Frame_Err), 32'd1);
    chk("late_rise_fs", 32'(o_Frame_Start), 32'd1);
    chk_cnt("late_rise", 0, 0);
    tick_n(TC * TR - 6);
    chk_cnt("late_next", 34, 11);
    tick();
    chk("realign_err", 32'(o_Frame_Err), 32'd1);
    chk("realign_fs", 32'(o_Frame_Start), 32'd1);
    err_seen = 0;
    tick_n(TC * TR);
    chk("relock1_lock", 32'(o_Locked), 32'd0);
    tick_n(TC * TR);
    chk("relock2_lock", 32'(o_Locked), 32'd1);
    chk("relock_err_seen", 32'(err_seen), 32'd0);

    // VSync pulse suppressed for one frame.
    novs = 1'b1;
    tick_n(TC * TR - 1);
    tick();
    novs = 1'b0;
    chk("miss_err", 32'(o_Frame_Err), 32'd1);
    chk("miss_fs", 32'(o_Frame_Start), 32'd0);
    chk_cnt("miss", 0, 0);
    chk("miss_lock", 32'(o_Locked), 32'd0);
    tick_n(2);
    chk_cnt("miss_run", 2, 0);
    chk("miss_run_err", 32'(o_Frame_Err), 32'd0);
    err_seen = 0;
    tick_n(TC * TR - 2);
    chk("miss_good_fs", 32'(o_Frame_Start), 32'd1);
    chk("miss_good_lock", 32'(o_Locked), 32'd0);
    tick_n(TC * TR);
    chk("miss_relock", 32'(o_Locked), 32'd1);
    chk("miss_err_seen", 32'(err_seen), 32'd0);

    // Reset mid-frame while locked.
    tick_n(5 * TC + 20);
    chk_cnt("pre_rst", 20, 5);
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    chk_cnt("mid_rst", 0, 0);
    chk("mid_rst_lock", 32'(o_Locked), 32'd0);
    chk("mid_rst_vs", 32'(o_VSync), 32'd1);
    err_seen = 0;
    wait_fs("post_rst");
    chk_cnt("post_rst", 0, 0);
    chk("post_rst_err", 32'(o_Frame_Err), 32'd0);
    chk("post_rst_err_seen", 32'(err_seen), 32'd0);
    chk("post_rst_lock", 32'(o_Locked), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
